// File: rtl/flop_arbiter.sv
// Arbiter that lets N requesters share one W-bit register, each winner holding it for HOLD cycles.
// Define FLOP_ARB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
module flop_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       d_flat,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 valid,
    output logic                 busy
);

    localparam int unsigned OwnW = $clog2(N);
    localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [W-1:0]    q_q, q_d;
    logic [OwnW-1:0] owner_q, owner_d;
    logic            valid_q, valid_d;
    logic [OwnW-1:0] win_idx;

`ifdef FLOP_ARB_RR_EN
    logic [OwnW-1:0] ptr_q, ptr_d;

    // Descending scan so the candidate closest to the pointer is assigned last.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % N]) begin
                win_idx = OwnW'((int'(ptr_q) + i) % N);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = OwnW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        valid_d = valid_q;
`ifdef FLOP_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req != '0) begin
                    q_d            = d_flat[win_idx*W +: W];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    valid_d        = 1'b1;
                    cnt_d          = CntW'(HOLD - 1);
                    state_d        = StHold;
`ifdef FLOP_ARB_RR_EN
                    ptr_d          = OwnW'((int'(win_idx) + 1) % N);
`endif
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
`ifdef FLOP_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
`ifdef FLOP_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign valid = valid_q;
    assign busy  = (state_q == StHold);

endmodule

// File: tb/tb_flop_arbiter.sv
// Self-checking bench for flop_arbiter: transaction-level model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_flop_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int HOLD = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] d_flat;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           valid;
    logic           busy;

    int tests = 0;
    int fails = 0;

    flop_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .d_flat (d_flat),
        .gnt    (gnt),
        .q      (q),
        .owner  (owner),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Transaction model: cycles left in the current grant, its owner and data.
    int         m_left;
    int         m_owner;
    logic [W-1:0] m_q;
    bit         m_fresh;

    function automatic int pick(input logic [N-1:0] r, input int last, input bit fresh);
        int start;
`ifdef FLOP_ARB_RR_EN
        start = fresh ? 0 : (last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left  <= 0;
            m_owner <= 0;
            m_q     <= '0;
            m_fresh <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (req != '0) begin
            m_left  <= HOLD;
            m_owner <= pick(req, m_owner, m_fresh);
            m_q     <= d_flat[pick(req, m_owner, m_fresh)*W +: W];
            m_fresh <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model.valid", int'(valid), (m_left > 0) ? 1 : 0);
            check("model.busy", int'(busy), (m_left > 0) ? 1 : 0);
            check("model.gnt", int'(gnt), (m_left > 0) ? (1 << m_owner) : 0);
            check("model.owner", int'(owner), m_owner);
            check("model.q", int'(q), int'(m_q));
        end
    end

    task automatic reset_pulse();
        reset_n = 1'b0;
        req     = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int got_owner [5];
    int got_cyc [5];
    int n_got;
    bit prev_valid;
    int exp_seq [5];

    initial begin
        reset_n = 1'b0;
        req     = N'($urandom);
        d_flat  = (N*W)'($urandom);
        repeat (3) @(negedge clk);
        check("reset.q", int'(q), 0);
        check("reset.gnt", int'(gnt), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.owner", int'(owner), 0);
        req     = '0;
        reset_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        req    = 4'b0100;
        d_flat = 16'h0A00;
        @(negedge clk);
        check("single.gnt", int'(gnt), 4);
        check("single.q", int'(q), 10);
        check("single.owner", int'(owner), 2);
        check("single.valid1", int'(valid), 1);
        req = '0;
        @(negedge clk);
        check("single.valid2", int'(valid), 1);
        @(negedge clk);
        check("single.end_gnt", int'(gnt), 0);
        check("single.end_valid", int'(valid), 0);
        check("single.end_q", int'(q), 10);

        // Contention with all requesters held high.
        reset_pulse();
        req    = 4'b1111;
        d_flat = 16'h4321;
        n_got  = 0;
        prev_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (valid && !prev_valid && n_got < 5) begin
                got_owner[n_got] = int'(owner);
                got_cyc[n_got]   = c;
                n_got++;
            end
            prev_valid = valid;
        end
        req = '0;
`ifdef FLOP_ARB_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        check("contend.count", n_got, 5);
        for (int i = 0; i < n_got; i++) begin
            check("contend.owner", got_owner[i], exp_seq[i]);
            check("contend.cycle", got_cyc[i], 1 + 3 * i);
        end

        // Input stability during HOLD.
        reset_pulse();
        req    = 4'b0010;
        d_flat = 16'h0050;
        @(negedge clk);
        check("stable.q0", int'(q), 5);
        check("stable.owner", int'(owner), 1);
        d_flat = 16'h00F0;
        req    = '0;
        @(negedge clk);
        check("stable.q1", int'(q), 5);
        check("stable.valid", int'(valid), 1);
        @(negedge clk);
        check("stable.done", int'(valid), 0);
        check("stable.q2", int'(q), 5);

        // Wrap-around from owner 3.
        reset_pulse();
        req    = 4'b1000;
        d_flat = 16'h9876;
        @(negedge clk);
        check("wrap.owner3", int'(owner), 3);
        req = '0;
        repeat (2) @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        check("wrap.owner0", int'(owner), 0);
        check("wrap.gnt", int'(gnt), 1);
        check("wrap.q", int'(q), 6);
        req = '0;
        repeat (2) @(negedge clk);

        // Asynchronous reset during the first HOLD cycle.
        reset_pulse();
        req    = 4'b0010;
        d_flat = 16'h00C0;
        @(negedge clk);
        check("abort.pre_valid", int'(valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort.gnt", int'(gnt), 0);
        check("abort.valid", int'(valid), 0);
        check("abort.busy", int'(busy), 0);
        check("abort.q", int'(q), 0);
        check("abort.owner", int'(owner), 0);
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b0010;
        @(negedge clk);
        check("abort.regrant", int'(gnt), 2);
        check("abort.reowner", int'(owner), 1);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
